// File: rtl/ccu_ctrl_wr_dispatch.sv
// CCU write-path front stage: classifies cached-master writes as snooping, bypass or
// locally answered, and steers AW/W/B so write ordering holds across the three paths.

package ccu_ctrl_wr_dispatch_pkg;

  typedef logic [3:0] acsnoop_t;
  typedef logic [3:0] id_t;

  localparam acsnoop_t AcCleanInvalid = 4'b1001;
  localparam acsnoop_t AcMakeInvalid  = 4'b1101;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef struct packed {
    id_t         id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_aw_chan_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [2:0]  snoop;
    logic [1:0]  domain;
    logic [1:0]  bar;
  } ace_aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    ace_aw_chan_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    logic         ar_valid;
    logic         r_ready;
    logic         wack;
    logic         rack;
  } ace_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    logic    r_valid;
  } ace_resp_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    logic    r_valid;
  } axi_resp_t;

endpackage

module ccu_ctrl_wr_dispatch
  import ccu_ctrl_wr_dispatch_pkg::*;
#(
  parameter int unsigned MaxBypassTxns = 4,
  parameter type slv_req_t  = ace_req_t,
  parameter type slv_resp_t = ace_resp_t,
  parameter type mst_req_t  = axi_req_t,
  parameter type mst_resp_t = axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output slv_req_t  snp_req_o,
  input  slv_resp_t snp_resp_i,
  output acsnoop_t  snp_trs_o,
  output mst_req_t  byp_req_o,
  input  mst_resp_t byp_resp_i
);

  localparam int unsigned CntW = $clog2(MaxBypassTxns + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxBypassTxns);

  typedef enum logic [1:0] {IDLE, SNOOP_ACT, LOCAL_B} state_e;
  typedef enum logic [1:0] {CLS_SNOOP, CLS_BYPASS, CLS_LOCAL} aw_class_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] byp_cnt_q, w_pend_q;
  b_chan_t         lat_b_q;

  aw_class_e  aw_class;
  acsnoop_t   aw_trs;
  logic [1:0] local_resp;
  logic       byp_aw_hs, byp_w_last_hs, byp_b_hs, local_hs;

  // AR/R and the acknowledge wires play no part in the write path.
  logic unused_inputs;
  assign unused_inputs = ^{slv_req_i.ar_valid, slv_req_i.r_ready, slv_req_i.wack,
                           slv_req_i.rack, snp_resp_i.ar_ready, snp_resp_i.r_valid,
                           byp_resp_i.ar_ready, byp_resp_i.r_valid};

  always_comb begin
    aw_class   = CLS_LOCAL;
    aw_trs     = '0;
    local_resp = RespSlverr;
    if (slv_req_i.aw.bar == 2'b00) begin
      if (slv_req_i.aw.domain == 2'b01 || slv_req_i.aw.domain == 2'b10) begin
        case (slv_req_i.aw.snoop)
          3'b000: begin aw_class = CLS_SNOOP; aw_trs = AcCleanInvalid; end
          3'b001: begin aw_class = CLS_SNOOP; aw_trs = AcMakeInvalid;  end
          3'b010, 3'b011, 3'b101: aw_class = CLS_BYPASS;
          3'b100: begin aw_class = CLS_LOCAL; local_resp = RespOkay; end
          default: ;
        endcase
      end else if (slv_req_i.aw.snoop == 3'b000) begin
        aw_class = CLS_BYPASS;
      end
    end
  end

  // NOTE: every output and flag gets a default before the case so no path leaves
  // one unassigned; otherwise synthesis infers latches.
  always_comb begin
    slv_resp_o    = '0;
    snp_req_o     = '0;
    byp_req_o     = '0;
    snp_trs_o     = '0;
    state_d       = state_q;
    byp_aw_hs     = 1'b0;
    byp_w_last_hs = 1'b0;
    byp_b_hs      = 1'b0;
    local_hs      = 1'b0;

    snp_req_o.aw       = slv_req_i.aw;
    snp_req_o.w        = slv_req_i.w;
    byp_req_o.aw.id    = slv_req_i.aw.id;
    byp_req_o.aw.addr  = slv_req_i.aw.addr;
    byp_req_o.aw.len   = slv_req_i.aw.len;
    byp_req_o.aw.size  = slv_req_i.aw.size;
    byp_req_o.aw.burst = slv_req_i.aw.burst;
    byp_req_o.w        = slv_req_i.w;

    // Handshakes are held off while reset is asserted, even on the combinational paths.
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          // SNOOP and LOCAL writes wait for all bypass writes to drain (ordering barrier).
          if (slv_req_i.aw_valid) begin
            unique case (aw_class)
              CLS_BYPASS: if (byp_cnt_q != MaxCnt) begin
                byp_req_o.aw_valid  = 1'b1;
                slv_resp_o.aw_ready = byp_resp_i.aw_ready;
                byp_aw_hs           = byp_resp_i.aw_ready;
              end
              CLS_SNOOP: if (byp_cnt_q == '0) begin
                snp_req_o.aw_valid  = 1'b1;
                snp_trs_o           = aw_trs;
                slv_resp_o.aw_ready = snp_resp_i.aw_ready;
                if (snp_resp_i.aw_ready) state_d = SNOOP_ACT;
              end
              default: if (byp_cnt_q == '0) begin
                slv_resp_o.aw_ready = 1'b1;
                local_hs            = 1'b1;
                state_d             = LOCAL_B;
              end
            endcase
          end
          if (w_pend_q != '0) begin
            byp_req_o.w_valid  = slv_req_i.w_valid;
            slv_resp_o.w_ready = byp_resp_i.w_ready;
            byp_w_last_hs      = slv_req_i.w_valid & byp_resp_i.w_ready & slv_req_i.w.last;
          end
          slv_resp_o.b       = byp_resp_i.b;
          slv_resp_o.b_valid = byp_resp_i.b_valid;
          byp_req_o.b_ready  = slv_req_i.b_ready;
          byp_b_hs           = byp_resp_i.b_valid & slv_req_i.b_ready;
        end
        SNOOP_ACT: begin
          snp_req_o.w_valid  = slv_req_i.w_valid;
          slv_resp_o.w_ready = snp_resp_i.w_ready;
          slv_resp_o.b       = snp_resp_i.b;
          slv_resp_o.b_valid = snp_resp_i.b_valid;
          snp_req_o.b_ready  = slv_req_i.b_ready;
          if (snp_resp_i.b_valid && slv_req_i.b_ready) state_d = IDLE;
        end
        LOCAL_B: begin
          slv_resp_o.b       = lat_b_q;
          slv_resp_o.b_valid = 1'b1;
          if (slv_req_i.b_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      byp_cnt_q <= '0;
      w_pend_q  <= '0;
      lat_b_q   <= '0;
    end else begin
      state_q <= state_d;
      if (byp_aw_hs && !byp_b_hs)      byp_cnt_q <= byp_cnt_q + CntW'(1);
      else if (!byp_aw_hs && byp_b_hs) byp_cnt_q <= byp_cnt_q - CntW'(1);
      if (byp_aw_hs && !byp_w_last_hs)      w_pend_q <= w_pend_q + CntW'(1);
      else if (!byp_aw_hs && byp_w_last_hs) w_pend_q <= w_pend_q - CntW'(1);
      if (local_hs) begin
        lat_b_q.id   <= slv_req_i.aw.id;
        lat_b_q.resp <= local_resp;
      end
    end
  end

endmodule

// File: tb/tb_ccu_ctrl_wr_dispatch.sv
// Directed bench for ccu_ctrl_wr_dispatch: the bench plays cached master, snoop stage
// and memory; expected B responses are queued at AW time and matched on B handshake.

module tb_ccu_ctrl_wr_dispatch;
  import ccu_ctrl_wr_dispatch_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_i = 1'b1;
  ace_req_t  slv_req;
  ace_resp_t slv_resp;
  ace_req_t  snp_req;
  ace_resp_t snp_resp;
  acsnoop_t  snp_trs;
  axi_req_t  byp_req;
  axi_resp_t byp_resp;

  int total = 0;
  int bad   = 0;
  b_chan_t sb[$];

  always #5 clk_i = ~clk_i;

  ccu_ctrl_wr_dispatch #(.MaxBypassTxns(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .snp_req_o  (snp_req),
    .snp_resp_i (snp_resp),
    .snp_trs_o  (snp_trs),
    .byp_req_o  (byp_req),
    .byp_resp_i (byp_resp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input logic [2:0] snoop, input logic [1:0] domain,
                        input logic [1:0] bar, input logic [3:0] id);
    slv_req.aw        = '0;
    slv_req.aw.snoop  = snoop;
    slv_req.aw.domain = domain;
    slv_req.aw.bar    = bar;
    slv_req.aw.id     = id;
    slv_req.aw.addr   = {28'h1000_000, id};
    slv_req.aw_valid  = 1'b1;
  endtask

  // Called at a negedge with the responder's B already driven; returns at a negedge.
  task automatic wait_b(input string tag);
    bit      seen = 1'b0;
    b_chan_t exp_b;
    slv_req.b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (slv_resp.b_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL %s_timeout: observed=no b_valid expected=b_valid within 20 cycles", tag);
    end else if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_unexpected: observed=b id %0h expected=no response", tag, slv_resp.b.id);
    end else begin
      exp_b = sb.pop_front();
      check({tag, "_id"}, 32'(slv_resp.b.id), 32'(exp_b.id));
      check({tag, "_resp"}, 32'(slv_resp.b.resp), 32'(exp_b.resp));
    end
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.b_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0] snoop;
    logic [1:0] domain;
    logic [1:0] bar;
    logic       byp_v;
    logic       snp_v;
    logic [3:0] trs;
    logic       rdy;
  } dec_vec_t;

  dec_vec_t dec_tbl[10] = '{
    '{3'b000, 2'b01, 2'b00, 1'b0, 1'b1, 4'b1001, 1'b0},
    '{3'b001, 2'b10, 2'b00, 1'b0, 1'b1, 4'b1101, 1'b0},
    '{3'b010, 2'b01, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0},
    '{3'b101, 2'b10, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0},
    '{3'b000, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0},
    '{3'b000, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0},
    '{3'b100, 2'b01, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b1},
    '{3'b011, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b1},
    '{3'b000, 2'b01, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b1},
    '{3'b110, 2'b01, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b1}
  };

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=bench still running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    slv_req  = '0;
    snp_resp = '0;
    byp_resp = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_aw_ready",  32'(slv_resp.aw_ready), 0);
    check("rst_b_valid",   32'(slv_resp.b_valid), 0);
    check("rst_snp_aw_v",  32'(snp_req.aw_valid), 0);
    check("rst_byp_aw_v",  32'(byp_req.aw_valid), 0);
    check("rst_snp_trs",   32'(snp_trs), 0);
    check("rst_ar_tied",   32'({slv_resp.ar_ready, slv_resp.r_valid, snp_req.ar_valid,
                                snp_req.wack, snp_req.rack, byp_req.ar_valid}), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Decode table, downstream not ready, valid dropped before the clock edge
    foreach (dec_tbl[k]) begin
      @(negedge clk_i);
      set_aw(dec_tbl[k].snoop, dec_tbl[k].domain, dec_tbl[k].bar, 4'(k));
      #1;
      check($sformatf("dec%0d_byp_v", k), 32'(byp_req.aw_valid), 32'(dec_tbl[k].byp_v));
      check($sformatf("dec%0d_snp_v", k), 32'(snp_req.aw_valid), 32'(dec_tbl[k].snp_v));
      check($sformatf("dec%0d_trs", k),   32'(snp_trs),          32'(dec_tbl[k].trs));
      check($sformatf("dec%0d_rdy", k),   32'(slv_resp.aw_ready), 32'(dec_tbl[k].rdy));
      slv_req.aw_valid = 1'b0;
    end

    // WriteUnique id=3 on the snoop path, 4 W beats, B forwarded
    @(negedge clk_i);
    snp_resp.aw_ready = 1'b1;
    set_aw(3'b000, 2'b01, 2'b00, 4'd3);
    #1;
    check("wu_snp_aw_v", 32'(snp_req.aw_valid), 1);
    check("wu_trs",      32'(snp_trs), 32'h9);
    check("wu_aw_ready", 32'(slv_resp.aw_ready), 1);
    check("wu_aw_id",    32'(snp_req.aw.id), 3);
    sb.push_back('{id: 4'd3, resp: RespOkay});
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.aw_valid  = 1'b0;
    snp_resp.aw_ready = 1'b0;
    snp_resp.w_ready  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      slv_req.w_valid = 1'b1;
      slv_req.w.data  = 32'hA000 + 32'(b);
      slv_req.w.last  = (b == 3);
      #1;
      check("wu_snp_w_v",   32'(snp_req.w_valid), 1);
      check("wu_snp_wdata", snp_req.w.data, 32'hA000 + 32'(b));
      check("wu_w_ready",   32'(slv_resp.w_ready), 1);
      check("wu_byp_w_v",   32'(byp_req.w_valid), 0);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    slv_req.w_valid  = 1'b0;
    snp_resp.w_ready = 1'b0;
    snp_resp.b       = '{id: 4'd3, resp: RespOkay};
    snp_resp.b_valid = 1'b1;
    wait_b("wu_b");
    snp_resp.b_valid = 1'b0;

    // W before its AW is held off; bypass WriteClean id=5 then releases two beats
    byp_resp.aw_ready = 1'b1;
    byp_resp.w_ready  = 1'b1;
    slv_req.w_valid   = 1'b1;
    slv_req.w.data    = 32'hB0;
    slv_req.w.last    = 1'b0;
    set_aw(3'b010, 2'b01, 2'b00, 4'd5);
    #1;
    check("wp0_w_ready",   32'(slv_resp.w_ready), 0);
    check("wp0_byp_w_v",   32'(byp_req.w_valid), 0);
    check("wc_aw_ready",   32'(slv_resp.aw_ready), 1);
    check("wc_byp_aw_id",  32'(byp_req.aw.id), 5);
    check("wc_byp_addr",   byp_req.aw.addr, 32'h1000_0005);
    sb.push_back('{id: 4'd5, resp: RespOkay});
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    #1;
    check("wc_w0_ready", 32'(slv_resp.w_ready), 1);
    check("wc_w0_byp_v", 32'(byp_req.w_valid), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.w.data = 32'hB1;
    slv_req.w.last = 1'b1;
    #1;
    check("wc_w1_ready", 32'(slv_resp.w_ready), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("wc_wpend0_ready", 32'(slv_resp.w_ready), 0);
    slv_req.w_valid  = 1'b0;
    byp_resp.b       = '{id: 4'd5, resp: RespOkay};
    byp_resp.b_valid = 1'b1;
    wait_b("wc_b");
    byp_resp.b_valid = 1'b0;

    // Four WriteBacks fill the bypass budget; the fifth waits for a B
    for (int i = 0; i < 4; i++) begin
      set_aw(3'b011, 2'b10, 2'b00, 4'(i));
      #1;
      check($sformatf("wb%0d_aw_ready", i), 32'(slv_resp.aw_ready), 1);
      check($sformatf("wb%0d_byp_v", i),    32'(byp_req.aw_valid), 1);
      sb.push_back('{id: 4'(i), resp: RespOkay});
      @(posedge clk_i);
      @(negedge clk_i);
    end
    slv_req.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slv_req.w_valid = 1'b1;
      slv_req.w.last  = 1'b1;
      slv_req.w.data  = 32'hC0 + 32'(i);
      #1;
      check($sformatf("wb%0d_w_ready", i), 32'(slv_resp.w_ready), 1);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    slv_req.w_valid = 1'b0;
    set_aw(3'b011, 2'b10, 2'b00, 4'd4);
    #1;
    check("wb4_full_ready", 32'(slv_resp.aw_ready), 0);
    check("wb4_full_byp_v", 32'(byp_req.aw_valid), 0);
    byp_resp.b       = '{id: 4'd0, resp: RespOkay};
    byp_resp.b_valid = 1'b1;
    wait_b("wb0_b");
    byp_resp.b_valid = 1'b0;
    #1;
    check("wb4_ready", 32'(slv_resp.aw_ready), 1);
    check("wb4_byp_v", 32'(byp_req.aw_valid), 1);
    sb.push_back('{id: 4'd4, resp: RespOkay});
    @(posedge clk_i);
    @(negedge clk_i);
    set_aw(3'b011, 2'b10, 2'b00, 4'd6);
    #1;
    check("wb5_full_ready", 32'(slv_resp.aw_ready), 0);
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b1;
    #1;
    check("wb4_w_ready", 32'(slv_resp.w_ready), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.w_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      byp_resp.b       = '{id: 4'(i), resp: RespOkay};
      byp_resp.b_valid = 1'b1;
      wait_b($sformatf("wb%0d_b", i));
      byp_resp.b_valid = 1'b0;
    end

    // WriteBack outstanding holds a WriteLineUnique until its B returns
    set_aw(3'b011, 2'b01, 2'b00, 4'd1);
    sb.push_back('{id: 4'd1, resp: RespOkay});
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.w_valid   = 1'b0;
    snp_resp.aw_ready = 1'b1;
    set_aw(3'b001, 2'b10, 2'b00, 4'd2);
    #1;
    check("wlu_held_ready", 32'(slv_resp.aw_ready), 0);
    check("wlu_held_snp_v", 32'(snp_req.aw_valid), 0);
    check("wlu_held_trs",   32'(snp_trs), 0);
    byp_resp.b       = '{id: 4'd1, resp: RespOkay};
    byp_resp.b_valid = 1'b1;
    wait_b("wlu_byp_b");
    byp_resp.b_valid = 1'b0;
    #1;
    check("wlu_snp_v", 32'(snp_req.aw_valid), 1);
    check("wlu_trs",   32'(snp_trs), 32'hD);
    check("wlu_ready", 32'(slv_resp.aw_ready), 1);
    sb.push_back('{id: 4'd2, resp: RespOkay});
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.aw_valid  = 1'b0;
    snp_resp.aw_ready = 1'b0;
    snp_resp.w_ready  = 1'b1;
    slv_req.w_valid   = 1'b1;
    slv_req.w.last    = 1'b1;
    #1;
    check("wlu_snp_w_v", 32'(snp_req.w_valid), 1);
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.w_valid  = 1'b0;
    snp_resp.w_ready = 1'b0;
    snp_resp.b       = '{id: 4'd2, resp: RespOkay};
    snp_resp.b_valid = 1'b1;
    wait_b("wlu_b");
    snp_resp.b_valid = 1'b0;

    // Evict id=7 answered locally with OKAY; no W taken while the B is pending
    set_aw(3'b100, 2'b01, 2'b00, 4'd7);
    #1;
    check("ev_aw_ready", 32'(slv_resp.aw_ready), 1);
    sb.push_back('{id: 4'd7, resp: RespOkay});
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    #1;
    check("ev_b_valid", 32'(slv_resp.b_valid), 1);
    check("ev_w_ready", 32'(slv_resp.w_ready), 0);
    check("ev_w_fwd",   32'({snp_req.w_valid, byp_req.w_valid}), 0);
    slv_req.w_valid = 1'b0;
    wait_b("ev_b");

    // Barrier write answered locally with SLVERR
    set_aw(3'b000, 2'b01, 2'b01, 4'd9);
    #1;
    check("bar_aw_ready", 32'(slv_resp.aw_ready), 1);
    check("bar_fwd",      32'({snp_req.aw_valid, byp_req.aw_valid}), 0);
    sb.push_back('{id: 4'd9, resp: RespSlverr});
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    wait_b("bar_b");

    // Reset while a snooping write is in flight, then a normal WriteUnique
    snp_resp.aw_ready = 1'b1;
    set_aw(3'b000, 2'b01, 2'b00, 4'd4);
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    snp_resp.w_ready = 1'b1;
    slv_req.w_valid  = 1'b1;
    #1;
    check("rsa_snp_w_v", 32'(snp_req.w_valid), 1);
    rst_i = 1'b1;
    #1;
    check("rsa_rst_w_v",     32'(snp_req.w_valid), 0);
    check("rsa_rst_w_ready", 32'(slv_resp.w_ready), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rsa_idle_w_ready", 32'(slv_resp.w_ready), 0);
    check("rsa_idle_w_fwd",   32'({snp_req.w_valid, byp_req.w_valid}), 0);
    slv_req.w_valid = 1'b0;
    snp_resp.w_ready = 1'b0;
    @(negedge clk_i);
    set_aw(3'b000, 2'b01, 2'b00, 4'd6);
    #1;
    check("rsa_wu_snp_v", 32'(snp_req.aw_valid), 1);
    check("rsa_wu_trs",   32'(snp_trs), 32'h9);
    sb.push_back('{id: 4'd6, resp: RespOkay});
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.aw_valid  = 1'b0;
    snp_resp.aw_ready = 1'b0;
    snp_resp.w_ready  = 1'b1;
    slv_req.w_valid   = 1'b1;
    slv_req.w.last    = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    slv_req.w_valid  = 1'b0;
    snp_resp.b       = '{id: 4'd6, resp: RespOkay};
    snp_resp.b_valid = 1'b1;
    wait_b("rsa_wu_b");
    snp_resp.b_valid = 1'b0;

    check("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
